// File: rtl/gpio_bus_arbiter_pkg.sv
// Shared constants for the gpio_controller register-port arbiter: data width,
// default timeout and the arbiter FSM encodings.
package gpio_bus_arbiter_pkg;

    localparam int XLEN             = 32;
    localparam int GPIO_ARB_TIMEOUT = 16;

    localparam logic [1:0] GARB_IDLE  = 2'd0;
    localparam logic [1:0] GARB_ISSUE = 2'd1;
    localparam logic [1:0] GARB_RESP  = 2'd2;
    localparam logic [1:0] GARB_GAP   = 2'd3;

    // Round-robin successor of a requester index, wrapping at n.
    function automatic int rr_advance(input int idx, input int n);
        int nxt;
        nxt = idx + 32'sd1;
        if (nxt >= n) begin
            nxt = 32'sd0;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/gpio_bus_arbiter_rr_priority_pick.sv
// Combinational round-robin picker: first pending index at or after the
// pointer, wrapping around. Reusable by other peripheral-bus arbiters.
module rr_priority_pick #(
    parameter int NUM_REQ = 2,
    localparam int IDW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_pending,
    input  logic [IDW-1:0]     i_rr_ptr,
    output logic               o_valid,
    output logic [IDW-1:0]     o_idx
);

    int w_sum;
    int w_slot;

    // Walk offsets from the far end back to zero so the nearest pending slot wins.
    always_comb begin
        o_valid = |i_pending;
        o_idx   = '0;
        w_sum   = 32'sd0;
        w_slot  = 32'sd0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            w_sum  = int'(i_rr_ptr) + off;
            w_slot = (w_sum >= NUM_REQ) ? (w_sum - NUM_REQ) : w_sum;
            o_idx  = i_pending[w_slot] ? IDW'(w_slot) : o_idx;
        end
    end

endmodule

// File: rtl/gpio_bus_arbiter.sv
// Round-robin arbiter sharing the gpio_controller register port among NUM_REQ
// masters, one transaction at a time, with a timeout for unmapped offsets.
module gpio_bus_arbiter
    import gpio_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = GPIO_ARB_TIMEOUT,
    localparam int IDW = $clog2(NUM_REQ),
    localparam int TW  = $clog2(TIMEOUT + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_read,
    input  logic [NUM_REQ-1:0]      req_write,
    input  logic [NUM_REQ*XLEN-1:0] req_addr,
    input  logic [NUM_REQ*XLEN-1:0] req_wdata,
    output logic [XLEN-1:0]         req_rdata,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      req_err,
    output logic [XLEN-1:0]         m_io_addr,
    output logic [XLEN-1:0]         m_io_wdata,
    output logic                    m_io_read,
    output logic                    m_io_write,
    input  logic [XLEN-1:0]         m_io_rdata,
    input  logic                    m_io_ready,
    output logic [IDW-1:0]          grant_id,
    output logic                    busy
);

    logic [1:0]         r_state;
    logic [IDW-1:0]     r_rr_ptr;
    logic [IDW-1:0]     r_grant;
    logic [TW-1:0]      r_tmo_cnt;
    logic [XLEN-1:0]    r_addr;
    logic [XLEN-1:0]    r_wdata;
    logic               r_read;
    logic               r_write;
    logic [XLEN-1:0]    r_rdata;
    logic [NUM_REQ-1:0] r_req_ready;
    logic [NUM_REQ-1:0] r_req_err;
    logic               r_busy;

    logic [NUM_REQ-1:0] w_pending;
    logic               w_pick_valid;
    logic [IDW-1:0]     w_pick_idx;
    logic [XLEN-1:0]    w_addr  [NUM_REQ];
    logic [XLEN-1:0]    w_wdata [NUM_REQ];

    assign w_pending = req_read | req_write;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign w_addr[k]  = req_addr[k*XLEN +: XLEN];
        assign w_wdata[k] = req_wdata[k*XLEN +: XLEN];
    end

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .i_pending (w_pending),
        .i_rr_ptr  (r_rr_ptr),
        .o_valid   (w_pick_valid),
        .o_idx     (w_pick_idx)
    );

    // Transaction sequencer. The counter gives up on the (TIMEOUT+1)th
    // ready-less ISSUE cycle, so the error lands TIMEOUT+2 cycles after the request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= GARB_IDLE;
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_tmo_cnt   <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_rdata     <= '0;
            r_req_ready <= '0;
            r_req_err   <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_req_ready <= '0;
            r_req_err   <= '0;
            case (r_state)
                GARB_IDLE: begin
                    if (w_pick_valid) begin
                        r_grant   <= w_pick_idx;
                        r_addr    <= w_addr[w_pick_idx];
                        r_wdata   <= w_wdata[w_pick_idx];
                        r_write   <= req_write[w_pick_idx];
                        r_read    <= ~req_write[w_pick_idx];
                        r_tmo_cnt <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= GARB_ISSUE;
                    end
                end
                GARB_ISSUE: begin
                    if (m_io_ready) begin
                        r_rdata              <= m_io_rdata;
                        r_read               <= 1'b0;
                        r_write              <= 1'b0;
                        r_req_ready[r_grant] <= 1'b1;
                        r_state              <= GARB_RESP;
                    end else if (r_tmo_cnt == TW'(TIMEOUT)) begin
                        r_rdata              <= '0;
                        r_read               <= 1'b0;
                        r_write              <= 1'b0;
                        r_req_ready[r_grant] <= 1'b1;
                        r_req_err[r_grant]   <= 1'b1;
                        r_state              <= GARB_RESP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TW'(1);
                    end
                end
                GARB_RESP: begin
                    r_rr_ptr <= IDW'(rr_advance(int'(r_grant), NUM_REQ));
                    r_state  <= GARB_GAP;
                end
                GARB_GAP: begin
                    // Controller ready is level-held; wait for it to fall before re-arbitrating.
                    if (!m_io_ready) begin
                        r_busy  <= 1'b0;
                        r_state <= GARB_IDLE;
                    end
                end
                default: begin
                    r_read  <= 1'b0;
                    r_write <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= GARB_IDLE;
                end
            endcase
        end
    end

    assign req_rdata  = r_rdata;
    assign req_ready  = r_req_ready;
    assign req_err    = r_req_err;
    assign m_io_addr  = r_addr;
    assign m_io_wdata = r_wdata;
    assign m_io_read  = r_read;
    assign m_io_write = r_write;
    assign grant_id   = r_grant;
    assign busy       = r_busy;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Directed bench for gpio_bus_arbiter with a small gpio_controller stand-in and
// a transaction-level model compared against the DUT every cycle.
module tb_gpio_bus_arbiter;
    import gpio_bus_arbiter_pkg::*;

    localparam int N   = 2;
    localparam int TMO = 16;

    logic                 clk   = 1'b0;
    logic                 rst_n = 1'b1;
    logic [N-1:0]         req_read, req_write;
    logic [N*XLEN-1:0]    req_addr, req_wdata;
    logic [XLEN-1:0]      req_rdata;
    logic [N-1:0]         req_ready, req_err;
    logic [XLEN-1:0]      m_io_addr, m_io_wdata, m_io_rdata;
    logic                 m_io_read, m_io_write, m_io_ready;
    logic [0:0]           grant_id;
    logic                 busy;

    logic [7:0]           pins;
    logic [XLEN-1:0]      ctl_cfg, ctl_out;

    int errors = 0;
    int checks = 0;

    // model state
    bit              m_act, m_wr, m_to, m_rknown;
    int              m_rel, m_len, m_g, m_rr;
    logic [0:0]      m_gid;
    logic [XLEN-1:0] m_addr, m_wdata, m_rdata, m_cfg, m_out;

    logic [N-1:0]    clr;

    always #5 clk = ~clk;

    gpio_bus_arbiter #(.NUM_REQ(N), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_read   (req_read),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rdata  (req_rdata),
        .req_ready  (req_ready),
        .req_err    (req_err),
        .m_io_addr  (m_io_addr),
        .m_io_wdata (m_io_wdata),
        .m_io_read  (m_io_read),
        .m_io_write (m_io_write),
        .m_io_rdata (m_io_rdata),
        .m_io_ready (m_io_ready),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    function automatic logic mapped(input logic [XLEN-1:0] a);
        return (a == 32'd0) || (a == 32'd4) || (a == 32'd8);
    endfunction

    // gpio_controller stand-in: registered level-held ready, offsets 0/4/8 only
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_io_ready <= 1'b0;
            m_io_rdata <= 32'd0;
            ctl_cfg    <= 32'd0;
            ctl_out    <= 32'd0;
        end else begin
            m_io_ready <= (m_io_read || m_io_write) && mapped(m_io_addr);
            m_io_rdata <= 32'd0;
            if (m_io_read) begin
                case (m_io_addr)
                    32'd0:   m_io_rdata <= ctl_cfg;
                    32'd4:   m_io_rdata <= ctl_out;
                    32'd8:   m_io_rdata <= {24'd0, pins};
                    default: m_io_rdata <= 32'd0;
                endcase
            end
            if (m_io_write && m_io_addr == 32'd0) ctl_cfg <= m_io_wdata;
            if (m_io_write && m_io_addr == 32'd4) ctl_out <= m_io_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] exp_read(input logic [XLEN-1:0] a);
        if (a == 32'd0) return m_cfg;
        if (a == 32'd4) return m_out;
        if (a == 32'd8) return {24'd0, pins};
        return 32'd0;
    endfunction

    // Transaction-level model: each granted access occupies a fixed schedule of
    // cycles relative to its grant (strobe, completion, gap, back to idle).
    task automatic model_loop();
        logic [N-1:0] e_rdy, e_err, pend;
        logic e_rd, e_wr, e_busy;
        int g, idx;
        forever begin
            @(negedge clk);
            e_rdy = '0; e_err = '0; e_rd = 1'b0; e_wr = 1'b0; e_busy = 1'b0;
            if (!rst_n) begin
                m_act = 1'b0; m_rel = 0; m_rr = 0; m_gid = 1'b0;
                m_addr = 32'd0; m_wdata = 32'd0; m_rdata = 32'd0; m_rknown = 1'b1;
                m_cfg = 32'd0; m_out = 32'd0;
            end else begin
                if (m_act && m_rel == m_len + 3) m_act = 1'b0;
                e_busy = m_act;
                if (m_act && m_rel <= m_len) begin
                    e_rd = !m_wr;
                    e_wr = m_wr;
                end
                if (m_act && m_rel == m_len + 1) begin
                    e_rdy[m_g] = 1'b1;
                    e_err[m_g] = m_to;
                    m_rr = (m_g + 1) % N;
                    if (m_to) begin
                        m_rdata = 32'd0; m_rknown = 1'b1;
                    end else if (m_wr) begin
                        m_rknown = 1'b0;
                    end else begin
                        m_rdata = exp_read(m_addr); m_rknown = 1'b1;
                    end
                end
            end
            chk("busy",       32'(busy),       32'(e_busy));
            chk("m_io_read",  32'(m_io_read),  32'(e_rd));
            chk("m_io_write", 32'(m_io_write), 32'(e_wr));
            chk("req_ready",  32'(req_ready),  32'(e_rdy));
            chk("req_err",    32'(req_err),    32'(e_err));
            chk("grant_id",   32'(grant_id),   32'(m_gid));
            chk("m_io_addr",  m_io_addr,       m_addr);
            chk("m_io_wdata", m_io_wdata,      m_wdata);
            if (m_rknown) chk("req_rdata", req_rdata, m_rdata);
            if (rst_n) begin
                if (m_act) begin
                    m_rel++;
                end else begin
                    pend = req_read | req_write;
                    g = -1;
                    for (int off = 0; off < N; off++) begin
                        idx = (m_rr + off) % N;
                        if (g < 0 && pend[idx]) g = idx;
                    end
                    if (g >= 0) begin
                        m_g     = g;
                        m_gid   = 1'(g);
                        m_wr    = req_write[g];
                        m_addr  = req_addr[g*XLEN +: XLEN];
                        m_wdata = req_wdata[g*XLEN +: XLEN];
                        m_to    = !mapped(m_addr);
                        m_len   = m_to ? TMO + 1 : 2;
                        m_act   = 1'b1;
                        m_rel   = 1;
                        if (m_wr && m_addr == 32'd0) m_cfg = m_wdata;
                        if (m_wr && m_addr == 32'd4) m_out = m_wdata;
                    end
                end
            end
        end
    endtask

    // one clock; requesters drop strobes the cycle after their req_ready
    task automatic step();
        @(posedge clk);
        #1;
        req_read  = req_read & ~clr;
        req_write = req_write & ~clr;
        clr       = req_ready;
    endtask

    task automatic post(input int k, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] d);
        req_read[k]              = rd;
        req_write[k]             = wr;
        req_addr[k*XLEN +: XLEN]  = a;
        req_wdata[k*XLEN +: XLEN] = d;
    endtask

    task automatic wait_ready(input int start, input int budget, output int lat, output int id);
        lat = start;
        id  = -1;
        while (id < 0 && lat < budget) begin
            step();
            lat++;
            for (int k = 0; k < N; k++) if (req_ready[k]) id = k;
        end
        if (id < 0) begin
            checks++;
            errors++;
            $display("FAIL wait_ready: no req_ready within %0d cycles", budget);
        end
    endtask

    initial begin
        int lat, id;
        req_read = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        clr = '0; pins = 8'h5A;
        fork
            model_loop();
        join_none
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_rdata", req_rdata, 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        rst_n = 1'b1;
        step();

        // simultaneous writes right after reset: 0, then 1, then 0 again
        post(0, 1'b0, 1'b1, 32'd4, 32'h11);
        post(1, 1'b0, 1'b1, 32'd4, 32'h22);
        wait_ready(0, 40, lat, id);
        chk("sim_first_lat", 32'(lat), 32'd3);
        chk("sim_first_id",  32'(id),  32'd0);
        chk("sim_first_strobe_low", 32'(m_io_write), 32'd0);
        wait_ready(lat, 40, lat, id);
        chk("sim_second_lat", 32'(lat), 32'd8);
        chk("sim_second_id",  32'(id),  32'd1);
        chk("sim_second_gid", 32'(grant_id), 32'd1);
        step(); step();
        post(0, 1'b0, 1'b1, 32'd4, 32'h33);
        post(1, 1'b0, 1'b1, 32'd4, 32'h44);
        wait_ready(0, 40, lat, id);
        chk("rereq_id", 32'(id), 32'd0);
        wait_ready(lat, 40, lat, id);
        chk("rereq_second_id", 32'(id), 32'd1);
        step(); step();

        // single read of pins
        post(0, 1'b1, 1'b0, 32'd8, 32'd0);
        step();
        chk("rd_strobe_c1", 32'(m_io_read), 32'd1);
        wait_ready(1, 40, lat, id);
        chk("rd_lat",   32'(lat), 32'd3);
        chk("rd_id",    32'(id),  32'd0);
        chk("rd_data",  req_rdata, 32'h5A);
        chk("rd_err",   32'(req_err), 32'd0);
        step(); step();

        // requester 1 writes config then reads it back
        post(1, 1'b0, 1'b1, 32'd0, 32'hFF);
        wait_ready(0, 40, lat, id);
        chk("wr_cfg_id", 32'(id), 32'd1);
        step(); step();
        post(1, 1'b1, 1'b0, 32'd0, 32'd0);
        wait_ready(0, 40, lat, id);
        chk("rd_cfg_data", req_rdata, 32'hFF);
        step(); step();

        // unmapped offset times out
        post(0, 1'b1, 1'b0, 32'd20, 32'd0);
        wait_ready(0, 40, lat, id);
        chk("tmo_lat",   32'(lat), 32'd18);
        chk("tmo_err",   32'(req_err), 32'd1);
        chk("tmo_rdata", req_rdata, 32'd0);
        step(); step();
        chk("tmo_idle",  32'(busy), 32'd0);

        // read and write together: write wins
        post(0, 1'b1, 1'b1, 32'd4, 32'hA5A5);
        step();
        chk("rw_write", 32'(m_io_write), 32'd1);
        chk("rw_read",  32'(m_io_read),  32'd0);
        wait_ready(1, 40, lat, id);
        step(); step();

        // reset during ISSUE of requester 1's read
        post(1, 1'b1, 1'b0, 32'd8, 32'd0);
        step(); step();
        rst_n = 1'b0;
        req_read = '0; req_write = '0; clr = '0;
        #1;
        chk("arst_busy",  32'(busy), 32'd0);
        chk("arst_read",  32'(m_io_read), 32'd0);
        chk("arst_addr",  m_io_addr, 32'd0);
        chk("arst_grant", 32'(grant_id), 32'd0);
        chk("arst_ready", 32'(req_ready), 32'd0);
        step();
        chk("arst_no_pulse", 32'(req_ready), 32'd0);
        step();
        rst_n = 1'b1;
        post(0, 1'b1, 1'b0, 32'd8, 32'd0);
        post(1, 1'b1, 1'b0, 32'd8, 32'd0);
        wait_ready(0, 40, lat, id);
        chk("post_rst_lat", 32'(lat), 32'd3);
        chk("post_rst_id",  32'(id),  32'd0);
        chk("post_rst_data", req_rdata, 32'h5A);
        wait_ready(lat, 40, lat, id);
        chk("post_rst_second_id", 32'(id), 32'd1);
        step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
